// File: rtl/instruction_encoder_loader.sv
// Packs R/I/J field sets into 32-bit instruction words, buffers them in a small FIFO and
// streams them into instruction memory at auto-incrementing addresses. Optional macro: LOADER_NOP_PAD_EN.
module instruction_encoder_loader #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  finish,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            fmt,
  input  logic [5:0]            op,
  input  logic [4:0]            rs,
  input  logic [4:0]            rt,
  input  logic [4:0]            rd,
  input  logic [4:0]            shamt,
  input  logic [5:0]            funct,
  input  logic [15:0]           immediate,
  input  logic [25:0]           address,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  err_illegal,
  output logic [ADDR_WIDTH:0]   word_count
);

  localparam int PW = $clog2(FIFO_DEPTH);

`ifdef LOADER_NOP_PAD_EN
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRAIN, S_PAD, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;
`endif

  state_t                r_state, w_next;
  logic [31:0]           r_fifo [FIFO_DEPTH];
  logic [PW:0]           r_wptr, r_rptr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_err;

  logic        w_empty, w_full, w_xfer, w_push, w_pop, w_wr, w_start, w_pad;
  logic [31:0] w_enc;

  function automatic logic [31:0] f_encode(
    input logic [1:0]  f,
    input logic [5:0]  o,
    input logic [4:0]  s,
    input logic [4:0]  t,
    input logic [4:0]  d,
    input logic [4:0]  sh,
    input logic [5:0]  fn,
    input logic [15:0] imm,
    input logic [25:0] adr
  );
    case (f)
      2'b00:   f_encode = {o, s, t, d, sh, fn};
      2'b01:   f_encode = {o, s, t, imm};
      2'b10:   f_encode = {o, adr};
      default: f_encode = 32'h0;
    endcase
  endfunction

  assign w_enc   = f_encode(fmt, op, rs, rt, rd, shamt, funct, immediate, address);
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[PW-1:0] == r_rptr[PW-1:0]) && (r_wptr[PW] != r_rptr[PW]);
  assign w_start = (r_state == S_IDLE) && start;

`ifdef LOADER_NOP_PAD_EN
  assign w_pad = (r_state == S_PAD);
`else
  assign w_pad = 1'b0;
`endif

  // Full blocks input even when a pop is completing this cycle.
  assign in_ready = (r_state == S_LOAD) && !w_full;
  assign w_xfer   = in_valid && in_ready;
  assign w_push   = w_xfer && (fmt != 2'b11);

  assign mem_we    = !w_empty || w_pad;
  assign mem_wdata = w_empty ? 32'h0 : r_fifo[r_rptr[PW-1:0]];
  assign mem_addr  = r_addr;
  assign w_wr      = mem_we && mem_ready;
  assign w_pop     = w_wr && !w_empty;

  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign err_illegal = r_err;
  assign word_count  = r_count;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_LOAD;
      S_LOAD:  if (finish) w_next = S_DRAIN;
`ifdef LOADER_NOP_PAD_EN
      S_DRAIN: if (w_empty) w_next = (r_addr[1:0] == 2'b00) ? S_DONE : S_PAD;
      S_PAD:   if (mem_ready && (r_addr[1:0] == 2'b11)) w_next = S_DONE;
`else
      S_DRAIN: if (w_empty) w_next = S_DONE;
`endif
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage carries no reset; occupancy is defined solely by the pointers.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wptr[PW-1:0]] <= w_enc;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr  <= ADDR_WIDTH'(BASE_ADDR);
      r_count <= '0;
      r_err   <= 1'b0;
    end else if (w_start) begin
      r_addr  <= ADDR_WIDTH'(BASE_ADDR);
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_wr) begin
        r_addr  <= r_addr + 1'b1;
        r_count <= r_count + 1'b1;
      end
      if (w_xfer && (fmt == 2'b11)) r_err <= 1'b1;
    end
  end

endmodule
